// File: rtl/wt_pkg.sv
// ----------------------------------------------------------------------------
// wt_pkg
// Shared definitions for the sequential Booth / carry-save multiplier.
//   wt_state_t    : 2-bit controller state encoding (IDLE, COMPRESS, FINAL, DONE)
//   booth_digit_t : radix-4 Booth digit encoding {0, +1, +2, -1, -2}
//   booth_recode  : maps a multiplier bit triplet {b[2k+1], b[2k], b[2k-1]}
//                   onto its Booth digit
// ----------------------------------------------------------------------------
package wt_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMPRESS = 2'd1,
      FINAL    = 2'd2,
      DONE     = 2'd3
   } wt_state_t;

   typedef enum logic [2:0] {
      BOOTH_ZERO = 3'd0,
      BOOTH_POS1 = 3'd1,
      BOOTH_POS2 = 3'd2,
      BOOTH_NEG1 = 3'd3,
      BOOTH_NEG2 = 3'd4
   } booth_digit_t;

   // Triplet value = -2*b[2k+1] + b[2k] + b[2k-1]
   function automatic booth_digit_t booth_recode(input logic [2:0] trip);
      booth_digit_t d;
      case (trip)
         3'b001, 3'b010: d = BOOTH_POS1;
         3'b011:         d = BOOTH_POS2;
         3'b100:         d = BOOTH_NEG2;
         3'b101, 3'b110: d = BOOTH_NEG1;
         default:        d = BOOTH_ZERO;   // 000, 111
      endcase
      return d;
   endfunction

endpackage

// File: rtl/wallace_seq_ctrl_csa_row.sv
// ----------------------------------------------------------------------------
// csa_row
// One row of WIDTH independent full adders (3:2 compressor).
//   i_x, i_y, i_z : three addend vectors
//   s             : bitwise sum      (x ^ y ^ z)
//   cout          : bitwise carry    (majority), weight 2 relative to s
// ----------------------------------------------------------------------------
module csa_row #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [WIDTH-1:0] i_z,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] cout
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         assign s[gi]    = i_x[gi] ^ i_y[gi] ^ i_z[gi];
         assign cout[gi] = (i_x[gi] & i_y[gi]) | (i_x[gi] & i_z[gi]) | (i_y[gi] & i_z[gi]);
      end
   endgenerate

endmodule

// File: rtl/wallace_seq_ctrl.sv
// ----------------------------------------------------------------------------
// wallace_seq_ctrl
// Sequential radix-4 Booth multiplier. One partial product per cycle is folded
// into a carry-save (sum, carry) pair through a single shared csa_row; a final
// carry-propagate add produces the registered product.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid_i   : operands valid
//   in_ready_o   : high in IDLE only
//   a_i, b_i     : multiplicand / multiplier, WIDTH bits
//   sign_i       : 1 = both operands two's complement, 0 = both unsigned
//   out_valid_o  : product valid (DONE only)
//   out_ready_i  : consumer accepts the product
//   product_o    : low 2*WIDTH bits of a*b
//
// Build option
//   WT_ZERO_SKIP_EN : when defined, an operation with a zero operand jumps
//                     straight from IDLE to DONE with product 0.
//
// Latency: counting the accepting edge as edge 1, out_valid_o rises after
// edge NPP+2 (1 accept + NPP compress + 1 final add).
// ----------------------------------------------------------------------------
module wallace_seq_ctrl
   import wt_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic                 sign_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [2*WIDTH-1:0]   product_o
);

   localparam int NPP = WIDTH / 2 + 1;    // radix-4 Booth partial products
   localparam int PW  = 2 * WIDTH;        // product width
   localparam int EW  = WIDTH + 2;        // extended operand width
   localparam int KW  = $clog2(NPP + 1);  // pp counter width

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   wt_state_t        r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sign;
   logic [PW-1:0]    r_sum;
   logic [PW-1:0]    r_carry;
   logic [KW-1:0]    r_k;
   logic [PW-1:0]    r_product;
   logic             r_out_valid;
   logic             r_in_ready;

   // ------------------------------------------------------------------
   // Operand extension and Booth partial product
   // ------------------------------------------------------------------
   logic [EW-1:0]  w_a_ext;
   logic [EW-1:0]  w_b_ext;
   logic [EW:0]    w_b_pad;      // extended multiplier with b[-1]=0 appended
   logic [EW:0]    w_b_shift;
   logic [PW-1:0]  w_a_sext;
   logic [PW-1:0]  w_mult;
   logic [PW-1:0]  w_pp;
   booth_digit_t   w_digit;
   logic [PW-1:0]  w_csa_s;
   logic [PW-1:0]  w_csa_c;

   assign w_a_ext  = {{2{r_sign & r_a[WIDTH-1]}}, r_a};
   assign w_b_ext  = {{2{r_sign & r_b[WIDTH-1]}}, r_b};
   assign w_b_pad  = {w_b_ext, 1'b0};

   // Select triplet k by shifting 2k positions; bits [2:0] are then
   // {b[2k+1], b[2k], b[2k-1]}.
   assign w_b_shift = w_b_pad >> {r_k, 1'b0};
   assign w_digit   = booth_recode(w_b_shift[2:0]);

   // The extended multiplicand is itself sign-extended to the product width;
   // for unsigned operands its top two bits are 0, so this is a zero fill.
   assign w_a_sext = {{(PW-EW){w_a_ext[EW-1]}}, w_a_ext};

   always_comb begin
      w_mult = '0;
      case (w_digit)
         BOOTH_POS1: w_mult = w_a_sext;
         BOOTH_POS2: w_mult = w_a_sext << 1;
         BOOTH_NEG1: w_mult = -w_a_sext;
         BOOTH_NEG2: w_mult = -(w_a_sext << 1);
         default:    w_mult = '0;
      endcase
   end

   assign w_pp = w_mult << {r_k, 1'b0};

   // ------------------------------------------------------------------
   // Shared compressor row: (sum, carry<<1, PP_k) -> (sum', carry')
   // ------------------------------------------------------------------
   csa_row #(
      .WIDTH (PW)
   ) u_csa_row (
      .i_x  (r_sum),
      .i_y  (r_carry << 1),
      .i_z  (w_pp),
      .s    (w_csa_s),
      .cout (w_csa_c)
   );

`ifdef WT_ZERO_SKIP_EN
   logic w_zero_op;
   assign w_zero_op = (a_i == '0) || (b_i == '0);
`endif

   // ------------------------------------------------------------------
   // Controller
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sign      <= 1'b0;
         r_sum       <= '0;
         r_carry     <= '0;
         r_k         <= '0;
         r_product   <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid_i && r_in_ready) begin
                  r_a        <= a_i;
                  r_b        <= b_i;
                  r_sign     <= sign_i;
                  r_sum      <= '0;
                  r_carry    <= '0;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
`ifdef WT_ZERO_SKIP_EN
                  if (w_zero_op) begin
                     r_product   <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_state     <= COMPRESS;
                  end
`else
                  r_state    <= COMPRESS;
`endif
               end
            end

            COMPRESS: begin
               r_sum   <= w_csa_s;
               r_carry <= w_csa_c;
               r_k     <= r_k + 1'b1;
               if (r_k == KW'(NPP - 1)) begin
                  r_state <= FINAL;
               end
            end

            FINAL: begin
               r_product   <= r_sum + (r_carry << 1);
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end

            DONE: begin
               // Product held until consumed; IDLE re-accepts one cycle later.
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign product_o   = r_product;

endmodule

// File: tb/tb_wallace_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wallace_seq_ctrl
// Randomized and directed checks of wallace_seq_ctrl (WIDTH=16) against a
// plain-arithmetic product model. Honors WT_ZERO_SKIP_EN when defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wallace_seq_ctrl;

   localparam int W   = 16;
   localparam int NPP = W / 2 + 1;

   logic            clk;
   logic            rst_n;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [W-1:0]    a_i;
   logic [W-1:0]    b_i;
   logic            sign_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [2*W-1:0]  product_o;

   int errors;
   int checks;

   wallace_seq_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .sign_i      (sign_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .product_o   (product_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer product of the operands as the mode interprets them.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      longint va;
      longint vb;
      longint p;
      va = longint'(a);
      vb = longint'(b);
      if (s && a[W-1]) va = va - (longint'(1) << W);
      if (s && b[W-1]) vb = vb - (longint'(1) << W);
      p = va * vb;
      return p[2*W-1:0];
   endfunction

   function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef WT_ZERO_SKIP_EN
      if (a == '0 || b == '0) return 1;
`endif
      return NPP + 2;
   endfunction

   // Full transaction: accept, count edges to out_valid, hold, handshake.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold);
      logic [2*W-1:0] exp_p;
      int edges;
      int waitc;
      exp_p = ref_mul(a, b, s);
      waitc = 0;
      @(negedge clk);
      while (!in_ready_o && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check("in_ready_idle", 64'(in_ready_o), 64'(1));
      in_valid_i = 1'b1;
      a_i = a;
      b_i = b;
      sign_i = s;
      @(posedge clk);                      // accepting edge = edge 1
      edges = 1;
      @(negedge clk);
      while (!out_valid_o && edges < 40) begin
         // operands offered while busy must be ignored
         in_valid_i = 1'b1;
         a_i = W'($urandom);
         b_i = W'($urandom);
         sign_i = 1'($urandom);
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      in_valid_i = 1'b0;
      check("latency", 64'(edges), 64'(ref_latency(a, b)));
      check("product", 64'(product_o), 64'(exp_p));
      check("in_ready_busy", 64'(in_ready_o), 64'(0));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", 64'(out_valid_o), 64'(1));
         check("hold_product", 64'(product_o), 64'(exp_p));
         check("hold_in_ready", 64'(in_ready_o), 64'(0));
      end
      out_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_i = 1'b0;
      check("post_valid", 64'(out_valid_o), 64'(0));
      check("post_in_ready", 64'(in_ready_o), 64'(1));
      $display("txn a=%04h b=%04h sign=%0d product=%08h expected=%08h latency=%0d hold=%0d",
               a, b, s, product_o, exp_p, edges, hold);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      in_valid_i = 1'b0;
      out_ready_i = 1'b0;
      a_i = '0;
      b_i = '0;
      sign_i = 1'b0;

      repeat (2) @(negedge clk);
      check("reset_valid", 64'(out_valid_o), 64'(0));
      check("reset_product", 64'(product_o), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 64'(in_ready_o), 64'(1));

      // Directed cases
      do_op(16'd3,    16'd5,    1'b0, 0);
      do_op(16'h8000, 16'h8000, 1'b1, 1);
      do_op(16'hFFFF, 16'h0002, 1'b1, 0);
      do_op(16'hFFFF, 16'hFFFF, 1'b0, 5);
      do_op(16'h8000, 16'h7FFF, 1'b1, 2);
      do_op(16'h0000, 16'h1234, 1'b0, 1);
      do_op(16'h1234, 16'h0000, 1'b1, 0);

      // Randomized cases, occasionally with a zero operand
      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 9) == 0) ra = '0;
         if ($urandom_range(0, 9) == 0) rb = '0;
         do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 4)));
      end

      // Reset while compressing (k=4); leave a non-zero product behind first
      do_op(16'd3, 16'd5, 1'b0, 0);
      @(negedge clk);
      in_valid_i = 1'b1;
      a_i = 16'd11;
      b_i = 16'd13;
      sign_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid_i = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid_o), 64'(0));
      check("midrst_product", 64'(product_o), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 64'(in_ready_o), 64'(1));
      check("midrst_no_output", 64'(out_valid_o), 64'(0));
      do_op(16'd7, 16'd9, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
